// File: rtl/grain_stream_decrypt_if.sv
// Stream and keystream-generator pins of the Grain-128a decryption front-end.
// master = decryptor side, slave = surrounding datapath / generator side.
interface grain_stream_decrypt_if;
    logic       ks_init;
    logic       ks_ready;
    logic       ks_bit;
    logic       ks_adv;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output ks_init, ks_adv, in_ready, out_data, out_valid,
        input  ks_ready, ks_bit, in_data, in_valid, out_ready
    );

    modport slave (
        input  ks_init, ks_adv, in_ready, out_data, out_valid,
        output ks_ready, ks_bit, in_data, in_valid, out_ready
    );
endinterface

// File: rtl/grain_stream_decrypt.sv
// Byte-wide Grain-128a decryption front-end: gathers keystream bits LSB-first into a byte
// and XORs it with ciphertext. Optional GRAIN_DEC_ABORT_EN adds an abort input.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | one-cycle ks_init pulse to the generator
// WARM  | waiting for generator ks_ready
// RUN   | gather keystream bytes, decrypt, hand out plaintext
module grain_stream_decrypt #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
`ifdef GRAIN_DEC_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    grain_stream_decrypt_if.master io
);

    typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_t;

    state_t           state;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] gathered;
    logic [LEN_W-1:0] sent;
    logic [2:0]       bitcnt;
    logic [7:0]       kbuf;
    logic             kvalid;
    logic [7:0]       out_data_r;
    logic             out_valid_r;
    logic             done_r;

    logic abort_i;
    logic gather_en;
    logic in_rdy;
    logic in_acc;
    logic out_acc;

`ifdef GRAIN_DEC_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign gather_en = (state == RUN) && !kvalid && (gathered < len_r) && io.ks_ready && !abort_i;
    assign in_rdy    = (state == RUN) && kvalid && (!out_valid_r || io.out_ready) && !abort_i;
    assign in_acc    = in_rdy && io.in_valid;
    assign out_acc   = out_valid_r && io.out_ready && !abort_i;

    assign io.ks_adv    = gather_en;
    assign io.ks_init   = (state == LOAD);
    assign io.in_ready  = in_rdy;
    assign io.out_data  = out_data_r;
    assign io.out_valid = out_valid_r;
    assign busy         = (state != IDLE);
    assign done         = done_r;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            len_r       <= '0;
            gathered    <= '0;
            sent        <= '0;
            bitcnt      <= '0;
            kbuf        <= '0;
            kvalid      <= 1'b0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort_i && state != IDLE) begin
                state       <= IDLE;
                kvalid      <= 1'b0;
                out_valid_r <= 1'b0;
                gathered    <= '0;
                sent        <= '0;
                bitcnt      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            len_r    <= msg_len;
                            gathered <= '0;
                            sent     <= '0;
                            bitcnt   <= '0;
                            kvalid   <= 1'b0;
                            if (msg_len == '0) done_r <= 1'b1;
                            else               state  <= LOAD;
                        end
                    end
                    LOAD: state <= WARM;
                    WARM: if (io.ks_ready) state <= RUN;
                    RUN: begin
                        if (gather_en) begin
                            kbuf[bitcnt] <= io.ks_bit;
                            if (bitcnt == 3'd7) begin
                                kvalid   <= 1'b1;
                                gathered <= gathered + LEN_W'(1);
                                bitcnt   <= '0;
                            end else begin
                                bitcnt <= bitcnt + 3'd1;
                            end
                        end
                        // A byte loaded in the same cycle as an output accept keeps out_valid high.
                        if (in_acc) begin
                            out_data_r  <= io.in_data ^ kbuf;
                            out_valid_r <= 1'b1;
                            kvalid      <= 1'b0;
                        end else if (out_acc) begin
                            out_valid_r <= 1'b0;
                        end
                        if (out_acc) begin
                            sent <= sent + LEN_W'(1);
                            if (sent + LEN_W'(1) == len_r) begin
                                done_r      <= 1'b1;
                                state       <= IDLE;
                                out_valid_r <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_grain_stream_decrypt.sv
// Directed bench for grain_stream_decrypt with a small keystream-generator model
// repeating bits 1,0,1,1,0,0,0,1 (byte 0x8D). Abort checks need GRAIN_DEC_ABORT_EN.
module tb_grain_stream_decrypt;

    typedef struct {
        int          len;
        logic [31:0] din;
        logic [31:0] exp;
        bit          stall;
        bit          drop;
        int          abort_at;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] msg_len = '0;
    logic        busy;
    logic        done;
`ifdef GRAIN_DEC_ABORT_EN
    logic        abort = 1'b0;
`endif

    grain_stream_decrypt_if io();

    grain_stream_decrypt #(.LEN_W(16)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (start),
        .msg_len (msg_len),
`ifdef GRAIN_DEC_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy),
        .done    (done),
        .io      (io)
    );

    always #5 clk = ~clk;

    // Generator model: reload on ks_init, 3-cycle warm-up, optional 20-cycle ready drop after bit 3.
    logic [7:0] pattern = 8'h8D;
    logic [2:0] idx = '0;
    int         warm = 0;
    int         hold = 0;
    bit         inited = 1'b0;
    bit         dropped = 1'b0;
    bit         drop_en = 1'b0;
    int         adv_cnt = 0;
    int         init_cnt = 0;
    int         adv_in_hold = 0;

    assign io.ks_bit   = pattern[idx];
    assign io.ks_ready = inited && (warm == 0) && (hold == 0);

    always @(posedge clk) begin
        if (io.ks_adv) adv_cnt <= adv_cnt + 1;
        if (io.ks_init) init_cnt <= init_cnt + 1;
        if (io.ks_adv && hold != 0) adv_in_hold <= adv_in_hold + 1;
        if (io.ks_init) begin
            idx     <= '0;
            warm    <= 3;
            hold    <= 0;
            dropped <= 1'b0;
            inited  <= 1'b1;
        end else begin
            if (warm != 0) warm <= warm - 1;
            if (hold != 0) hold <= hold - 1;
            if (io.ks_adv) begin
                idx <= idx + 3'd1;
                if (drop_en && !dropped && idx == 3'd2) begin
                    hold    <= 20;
                    dropped <= 1'b1;
                end
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {48'd0, busy, done, io.ks_init, io.ks_adv, io.in_ready, io.out_valid, 2'b00, io.out_data};
    endfunction

    task automatic run_msg(input vec_t v);
        int         ii;
        int         oi;
        int         adv0;
        int         init0;
        int         hold0;
        int         a;
        bit         fin;
        bit         stalled;
        bit         aborted;
        bit         ok;
        logic [7:0] held;
        ii = 0; oi = 0; fin = 0; stalled = 0; aborted = 0;
        drop_en = v.drop;
        adv0 = adv_cnt; init0 = init_cnt; hold0 = adv_in_hold;
        io.out_ready = 1'b1;
        io.in_valid  = 1'b0;
        @(negedge clk);
        start = 1'b1; msg_len = 16'(v.len);
        @(negedge clk);
        start = 1'b0;
        chk("ks_init_after_start", {63'd0, io.ks_init}, 64'd1);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            io.in_valid = (ii < v.len);
            io.in_data  = (ii < v.len) ? v.din[8*ii +: 8] : 8'h00;
            io.out_ready = 1'b1;
            if (v.stall && !stalled && oi == 1 && io.out_valid) begin
                held = io.out_data; a = adv_cnt; ok = 1;
                io.out_ready = 1'b0;
                repeat (50) begin
                    @(negedge clk);
                    if (io.out_data !== held || io.in_ready !== 1'b0 || io.out_valid !== 1'b1) ok = 0;
                end
                chk("stall_hold_stable", {63'd0, ok}, 64'd1);
                chk("stall_ks_adv", 64'(adv_cnt - a), 64'd8);
                stalled = 1;
                io.out_ready = 1'b1;
            end
`ifdef GRAIN_DEC_ABORT_EN
            if (v.abort_at != 0 && oi == v.abort_at) begin
                abort = 1'b1; io.in_valid = 1'b0; io.out_ready = 1'b0;
                #1;
                chk("abort_cycle_adv_rdy", {62'd0, io.ks_adv, io.in_ready}, 64'd0);
                @(negedge clk);
                abort = 1'b0;
                chk("abort_idle", {61'd0, busy, done, io.out_valid}, 64'd0);
                @(negedge clk);
                chk("abort_no_done", {63'd0, done}, 64'd0);
                aborted = 1; fin = 1;
            end
`endif
            if (!fin) begin
                #1;
                if (io.in_valid && io.in_ready) ii++;
                if (io.out_valid && io.out_ready) begin
                    chk($sformatf("out_byte%0d_len%0d", oi, v.len), 64'(io.out_data), 64'(v.exp[8*oi +: 8]));
                    oi++;
                    if (oi == v.len) begin
                        @(negedge clk);
                        io.in_valid = 1'b0;
                        chk("done_after_last", {62'd0, done, busy}, 64'd2);
                        @(negedge clk);
                        chk("done_one_cycle", {63'd0, done}, 64'd0);
                        fin = 1;
                    end
                end
                if (!fin) @(negedge clk);
            end
        end
        io.in_valid = 1'b0;
        if (!fin) chk("msg_timeout", 64'(oi), 64'(v.len));
        if (!aborted) begin
            chk("ks_adv_total", 64'(adv_cnt - adv0), 64'(8 * v.len));
            chk("ks_init_count", 64'(init_cnt - init0), 64'd1);
        end
        if (v.drop) begin
            chk("drop_happened", {63'd0, dropped}, 64'd1);
            chk("drop_no_adv", 64'(adv_in_hold - hold0), 64'd0);
        end
        drop_en = 1'b0;
    endtask

    vec_t vecs[5];
    vec_t vab;

    initial begin
        vecs[0] = '{len: 1, din: 32'h00000000, exp: 32'h0000008D, stall: 0, drop: 0, abort_at: 0};
        vecs[1] = '{len: 4, din: 32'h55AA00FF, exp: 32'hD8278D72, stall: 0, drop: 0, abort_at: 0};
        vecs[2] = '{len: 4, din: 32'h55AA00FF, exp: 32'hD8278D72, stall: 1, drop: 0, abort_at: 0};
        vecs[3] = '{len: 2, din: 32'h0000128D, exp: 32'h00009F00, stall: 0, drop: 1, abort_at: 0};
        vecs[4] = '{len: 3, din: 32'h00FE8001, exp: 32'h00730D8C, stall: 0, drop: 0, abort_at: 0};
        io.in_data = '0; io.in_valid = 1'b0; io.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_outputs_%0d", i), all_outs(), 64'd0);
        end

        begin : zero_len
            int init0;
            init0 = init_cnt;
            start = 1'b1; msg_len = 16'd0;
            @(negedge clk);
            start = 1'b0;
            chk("zero_len_done", {61'd0, done, busy, io.ks_init}, 64'd4);
            @(negedge clk);
            chk("zero_len_done_pulse", {62'd0, done, busy}, 64'd0);
            chk("zero_len_no_init", 64'(init_cnt - init0), 64'd0);
        end

        for (int i = 0; i < 5; i++) run_msg(vecs[i]);

        // Reset in the middle of a message, then a full message from scratch.
        @(negedge clk);
        start = 1'b1; msg_len = 16'd4;
        @(negedge clk);
        start = 1'b0; io.in_valid = 1'b1; io.in_data = 8'h11; io.out_ready = 1'b1;
        repeat (15) @(negedge clk);
        n_reset = 1'b0;
        #1;
        chk("mid_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        n_reset = 1'b1; io.in_valid = 1'b0;
        run_msg(vecs[1]);

`ifdef GRAIN_DEC_ABORT_EN
        vab = vecs[1];
        vab.abort_at = 2;
        run_msg(vab);
        run_msg(vecs[1]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
